// File: rtl/spi_iram_loader.sv
// SPI-slave (mode 0, MSB first) boot loader that writes 16-bit words into iram and gates the CPU halt.
// Pins are oversampled in clk; write strobe lands 3 clk after the SCK edge carrying the last data bit.
module spi_iram_loader #(
    parameter int ADDR_W        = 13,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nCS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              iram_we,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [15:0]       iram_wdata,
    output logic              cpu_hold,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, IGNORE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ncs_q, sck_q;
    logic [1:0]        mosi_q;
    logic [6:0]        shift_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;

    logic              ncs_fall, ncs_rise, sck_rise, bit_take;
    logic              byte_vld;
    logic [7:0]        byte_dat;
    logic [15:0]       addr_full;

    // Index 1 is the synchronized level, index 2 the previous one for edge detection.
    assign ncs_fall  = ncs_q[2] & ~ncs_q[1];
    assign ncs_rise  = ~ncs_q[2] & ncs_q[1];
    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign bit_take  = sck_rise & ~ncs_q[1];
    assign byte_dat  = {shift_q, mosi_q[1]};
    assign byte_vld  = bit_take & (bit_cnt_q == 3'd7);
    assign addr_full = {addr_hi_q, byte_dat};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ncs_q     <= 3'b111;
            sck_q     <= 3'b000;
            mosi_q    <= 2'b00;
            shift_q   <= 7'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            ncs_q  <= {ncs_q[1:0], nCS};
            sck_q  <= {sck_q[1:0], SCK};
            mosi_q <= {mosi_q[0], MOSI};
            if (ncs_fall) begin
                bit_cnt_q <= 3'd0;
            end else if (bit_take) begin
                shift_q   <= byte_dat[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_hi_q <= 8'd0;
            data_hi_q <= 8'd0;
            addr_q    <= '0;
            wdata_q   <= 16'd0;
            we_q      <= 1'b0;
            hold_q    <= HOLD_AT_RESET;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            data_hi_q <= data_hi_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        data_hi_d = data_hi_q;
        addr_d    = we_q ? addr_q + ADDR_W'(1) : addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        hold_d    = hold_q;
        // Deselect wins over a byte completing in the same cycle; a half word is simply dropped.
        if (ncs_rise) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (ncs_fall) state_d = CMD;
        end else if (byte_vld) begin
            case (state_q)
                CMD: begin
                    case (byte_dat)
                        8'h01:   state_d = ADDR_HI;
                        8'h02:   begin hold_d = 1'b0; state_d = IGNORE; end
                        8'h03:   begin hold_d = 1'b1; state_d = IGNORE; end
                        default: state_d = IGNORE;
                    endcase
                end
                ADDR_HI: begin
                    addr_hi_d = byte_dat;
                    state_d   = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_d  = addr_full[ADDR_W-1:0];
                    state_d = DATA_HI;
                end
                DATA_HI: begin
                    data_hi_d = byte_dat;
                    state_d   = DATA_LO;
                end
                DATA_LO: begin
                    wdata_d = {data_hi_q, byte_dat};
                    we_d    = 1'b1;
                    state_d = DATA_HI;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign iram_we    = we_q;
    assign iram_addr  = addr_q;
    assign iram_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign busy       = ~ncs_q[1];

endmodule

// File: tb/tb_spi_iram_loader.sv
// Bench for spi_iram_loader: directed and random SPI frames scored against a byte-stream frame model.
module tb_spi_iram_loader;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          nCS = 1'b1;
    logic          SCK = 1'b0;
    logic          MOSI = 1'b0;
    logic          iram_we;
    logic [AW-1:0] iram_addr;
    logic [15:0]   iram_wdata;
    logic          cpu_hold;
    logic          busy;

    spi_iram_loader #(.ADDR_W(AW), .HOLD_AT_RESET(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .nCS        (nCS),
        .SCK        (SCK),
        .MOSI       (MOSI),
        .iram_we    (iram_we),
        .iram_addr  (iram_addr),
        .iram_wdata (iram_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int             n_vec = 0;
    int             n_err = 0;
    int             cyc = 0;
    int             last_rise = 0;
    bit             in_rst = 1'b1;
    logic           prev_hold = 1'b1;
    logic [AW+15:0] obs_q[$];
    logic [AW+15:0] exp_q[$];
    logic [7:0]     fb[$];
    logic [AW-1:0]  m_addr = '0;
    logic [15:0]    m_wdata = '0;
    logic           m_hold = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (iram_we) begin
            obs_q.push_back({iram_addr, iram_wdata});
            chk("we_latency_ok", 32'((cyc - last_rise) <= 5), 32'd1);
        end
        if (!in_rst && cpu_hold !== prev_hold)
            chk("hold_latency_ok", 32'((cyc - last_rise) <= 5), 32'd1);
        prev_hold = cpu_hold;
    end

    // Frame semantics from the byte list: cmd, addr hi, addr lo, then complete hi/lo pairs.
    task automatic model_frame();
        int            n;
        logic [15:0]   full;
        logic [AW-1:0] a;
        n = fb.size();
        if (n == 0) return;
        case (fb[0])
            8'h01: if (n >= 3) begin
                full = {fb[1], fb[2]};
                a    = full[AW-1:0];
                for (int i = 3; i + 1 < n; i += 2) begin
                    exp_q.push_back({a, fb[i], fb[i+1]});
                    m_wdata = {fb[i], fb[i+1]};
                    a = a + 1'b1;
                end
                m_addr = a;
            end
            8'h02: m_hold = 1'b0;
            8'h03: m_hold = 1'b1;
            default: ;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk); MOSI = b[i];
            repeat (4) @(negedge clk);
            SCK = 1'b1; last_rise = cyc;
            repeat (4) @(negedge clk);
            SCK = 1'b0;
        end
    endtask

    task automatic score();
        logic [AW+15:0] o, e;
        chk("n_writes", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk("write_addr_data", 32'(o), 32'(e));
        end
        obs_q.delete();
        exp_q.delete();
        chk("iram_addr", 32'(iram_addr), 32'(m_addr));
        chk("iram_wdata", 32'(iram_wdata), 32'(m_wdata));
        chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input int part_bits);
        @(negedge clk); nCS = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_in_frame", 32'(busy), 32'd1);
        foreach (fb[i]) send_byte(fb[i], 8);
        if (part_bits > 0) send_byte(8'h5A, part_bits);
        repeat (6) @(negedge clk); nCS = 1'b1;
        repeat (12) @(negedge clk);
        model_frame();
        score();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, len, pb;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(iram_we), 32'd0);
        chk("rst_addr", 32'(iram_addr), 32'd0);
        chk("rst_wdata", 32'(iram_wdata), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        in_rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_hold", 32'(cpu_hold), 32'd1);
        chk("idle_no_writes", obs_q.size(), 32'd0);
        chk("idle_addr", 32'(iram_addr), 32'd0);

        fb = {8'h01, 8'h00, 8'h00, 8'h80, 8'h03, 8'h81, 8'h01, 8'h0D, 8'hC0}; run_frame(0);
        fb = {8'h01, 8'h00, 8'h10, 8'h80, 8'h20, 8'h08, 8'h40};               run_frame(0);
        fb = {8'h02};                                                         run_frame(0);
        fb = {8'h03};                                                         run_frame(0);
        fb = {8'h01, 8'h1F, 8'hFF, 8'h60, 8'h0A, 8'h40, 8'h05};               run_frame(0);
        fb = {8'h01, 8'h00, 8'h05, 8'h09, 8'hC0, 8'h04};                      run_frame(4);
        fb = {8'h01, 8'h00, 8'h06, 8'h12, 8'h34};                             run_frame(0);
        fb = {8'h7E, 8'h01, 8'h00, 8'h01, 8'h02};                             run_frame(0);
        fb = {8'h01, 8'hE0, 8'h21, 8'hAB};                                    run_frame(0);

        for (int f = 0; f < 20; f++) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 9);
            fb.delete();
            if (r < 6)       fb.push_back(8'h01);
            else if (r == 6) fb.push_back(8'h02);
            else if (r == 7) fb.push_back(8'h03);
            else             fb.push_back(8'($urandom_range(4, 255)));
            for (int k = 1; k < len; k++) fb.push_back(8'($urandom));
            pb = (r % 3 == 0) ? $urandom_range(0, 7) : 0;
            run_frame(pb);
        end

        // Hold the CPU running, then abort a write frame with reset mid-word.
        fb = {8'h02}; run_frame(0);
        @(negedge clk); nCS = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'h01, 8); send_byte(8'h00, 8); send_byte(8'h07, 8);
        send_byte(8'hAA, 8); send_byte(8'h55, 4);
        in_rst = 1'b1;
        reset  = 1'b0;
        #1;
        chk("arst_we", 32'(iram_we), 32'd0);
        chk("arst_addr", 32'(iram_addr), 32'd0);
        chk("arst_wdata", 32'(iram_wdata), 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        nCS = 1'b1; SCK = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        in_rst = 1'b0;
        repeat (20) @(negedge clk);
        exp_q.delete();
        m_addr = '0; m_wdata = '0; m_hold = 1'b1;
        fb.delete();
        score();
        fb = {8'h01, 8'h00, 8'h02, 8'hBE, 8'hEF}; run_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_iram_loader.md
Name: spi_iram_loader

Overview:
- SPI-slave boot loader directly upstream of the CPU core's instruction RAM.
- Receives frames on nCS/SCK/MOSI and writes 16-bit instruction words into iram through a single write port.
- Holds the CPU in halt while loading and releases it on command, so programs load over the wire rather than by bench preload.
- Runs entirely in the clk domain; the SPI pins are oversampled.

Parameters:
- ADDR_W, 13, iram word-address width; the address counter wraps modulo 2^ADDR_W.
- HOLD_AT_RESET, 1, reset value of cpu_hold (1 = CPU halted after reset).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- nCS  input  1  SPI chip select, active low, asynchronous to clk.
- SCK  input  1  SPI clock, mode 0 (sample on rising edge), asynchronous; f_SCK <= f_clk/8.
- MOSI  input  1  SPI data, MSB first.
- iram_we  output  1  one-cycle write strobe to iram.
- iram_addr  output  ADDR_W  iram write word address.
- iram_wdata  output  16  iram write data.
- cpu_hold  output  1  1 = CPU core held in reset/halt.
- busy  output  1  1 while a frame is in progress (synchronized nCS low).

Behaviour:
- Reset (reset=0, asynchronous) drives iram_we=0, iram_addr=0, iram_wdata=0, cpu_hold=HOLD_AT_RESET, busy=0, state=IDLE, bit counter=0. Reset asserted mid-frame aborts the frame with no write.
- Synchronizers: nCS, SCK and MOSI each pass through 2 flops. SCK rising and nCS falling/rising edges are detected on the synchronized signals.
- Byte assembler:
  - On each synchronized SCK rise while synchronized nCS=0, shift MOSI into an 8-bit register and increment a 3-bit counter.
  - On wrap to 0, pulse byte_valid for one clk.
  - A falling edge of nCS clears the counter.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, IGNORE.
  - IDLE -> CMD on nCS falling edge.
  - CMD on byte: 0x01 -> ADDR_HI; 0x02 -> cpu_hold<=0, IGNORE; 0x03 -> cpu_hold<=1, IGNORE; any other value -> IGNORE.
  - ADDR_HI on byte: latch addr[15:8] -> ADDR_LO.
  - ADDR_LO on byte: latch addr[7:0]; iram_addr<=addr[ADDR_W-1:0]; -> DATA_HI. Address bits at and above ADDR_W are discarded.
  - DATA_HI on byte: latch the high byte -> DATA_LO.
  - DATA_LO on byte: iram_wdata<={hi,byte}; iram_we=1 for exactly one clk; -> DATA_HI. iram_addr increments by 1 in the cycle after the strobe and wraps from 2^ADDR_W-1 to 0.
  - Any state -> IDLE on nCS rising edge.
- Write timing:
  - iram_we rises within 5 clk of the SCK rising edge carrying the last bit of a low byte.
  - iram_addr/iram_wdata are stable during the strobe cycle.
- Partial data: nCS rising with state=DATA_LO, or with the bit counter non-zero, discards the partial word. No write occurs.
- Write commands never change cpu_hold. The loader writes iram regardless of cpu_hold; hosts issue HALT before loading.
- busy equals the inverse of synchronized nCS.
- Data bytes after RUN or HALT within the same frame are ignored.

Test Plan:
- Reset release with HOLD_AT_RESET=1, no SPI activity -> cpu_hold=1, iram_we never asserted, iram_addr=0.
- Frame 01 00 00 80 03 81 01 0D C0 -> three strobes: addr0=0x8003, addr1=0x8101, addr2=0x0DC0. iram_addr ends at 3.
- Frame 01 00 10 80 20 08 40, then frame 02 -> addr0x10=0x8020, addr0x11=0x0840, then cpu_hold falls to 0 within 5 clk of the last bit; a following frame 03 sets cpu_hold=1.
- Frame 01 1F FF 60 0A 40 05 with ADDR_W=13 -> addr0x1FFF=0x600A, then addr0x0000=0x4005 (wrap).
- Frame 01 00 05 09 C0 04, then nCS raised after 4 bits of the next byte -> exactly one write (addr5=0x09C0). The partial word is dropped and the next frame starts cleanly at CMD.
- Frame with command 0x7E followed by 4 bytes -> no writes, cpu_hold unchanged. reset pulsed low mid-data in a write frame -> outputs return to reset values immediately and the pending word is not written.
